// File: rtl/adc_cmd_sequencer.sv
// rtl/adc_cmd_sequencer.sv - round-robin ADC command sequencer with per-slot result capture
//
// Purpose: scans NUM_CH consecutive ADC channels starting at FIRST_CH. At most
// one command is outstanding; each slot completes on a matching response or a
// timeout. The latest result of every slot is published on sample_data.
//
// Optional feature macro: ADC_SEQ_AVG_EN
//   defined   - each slot averages 4 matching results (14-bit sum, >>2)
//   undefined - every matching result is published directly
//
// Ports:
//   clk_clk            in   rising-edge clock
//   reset_reset        in   synchronous active-high reset
//   enable             in   1 = scan continuously, 0 = stop after current slot
//   cmd_valid          out  command valid (Avalon-ST source)
//   cmd_channel        out  [4:0] requested channel
//   cmd_startofpacket  out  start of packet (single-beat command)
//   cmd_endofpacket    out  end of packet (single-beat command)
//   cmd_ready          in   ADC accepts the command
//   rsp_valid          in   response valid (no backpressure)
//   rsp_channel        in   [4:0] channel of the response
//   rsp_data           in   [11:0] conversion result
//   rsp_startofpacket  in   ignored
//   rsp_endofpacket    in   ignored
//   sample_data        out  [12*NUM_CH-1:0] latest result, slot i at [12i+11:12i]
//   sample_strobe      out  one-cycle pulse when a slot is updated
//   sample_slot        out  [2:0] slot updated, valid with sample_strobe
//   scan_done          out  one-cycle pulse when the last slot completes
//   err_timeout        out  sticky, a response timed out
//   err_mismatch       out  sticky, a response carried an unexpected channel
module adc_cmd_sequencer #(
  parameter int FIRST_CH = 1,
  parameter int NUM_CH   = 6,
  parameter int TIMEOUT  = 1023
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   enable,
  output logic                   cmd_valid,
  output logic [4:0]             cmd_channel,
  output logic                   cmd_startofpacket,
  output logic                   cmd_endofpacket,
  input  logic                   cmd_ready,
  input  logic                   rsp_valid,
  input  logic [4:0]             rsp_channel,
  input  logic [11:0]            rsp_data,
  input  logic                   rsp_startofpacket,
  input  logic                   rsp_endofpacket,
  output logic [12*NUM_CH-1:0]   sample_data,
  output logic                   sample_strobe,
  output logic [2:0]             sample_slot,
  output logic                   scan_done,
  output logic                   err_timeout,
  output logic                   err_mismatch
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_slot;
  logic [CW-1:0]       r_cnt;
  logic [12*NUM_CH-1:0] r_sample_data;
  logic                r_strobe;
  logic [2:0]          r_sample_slot;
  logic                r_done;
  logic                r_err_to;
  logic                r_err_mm;

  logic [4:0]          w_exp_ch;
  logic                w_accept;
  logic                w_match;
  logic                w_mismatch;
  logic                w_timeout;
  logic                w_publish;
  logic [11:0]         w_pub_data;
  logic                w_advance;
  logic [2:0]          w_slot_next;
  logic                w_unused;

  // SOP/EOP of responses carry no information for single-beat results.
  assign w_unused = &{1'b0, rsp_startofpacket, rsp_endofpacket};

  assign w_slot_next = (r_slot == 3'(NUM_CH - 1)) ? 3'd0 : r_slot + 3'd1;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command outputs decode from state only, so the channel is stable for as
  // long as ISSUE waits on cmd_ready.
  always_comb begin
    w_next_state      = r_state;
    w_exp_ch          = 5'(FIRST_CH) + {2'b00, r_slot};
    w_accept          = 1'b0;
    w_match           = 1'b0;
    w_mismatch        = 1'b0;
    w_timeout         = 1'b0;
    cmd_valid         = 1'b0;
    cmd_channel       = 5'd0;
    cmd_startofpacket = 1'b0;
    cmd_endofpacket   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid         = 1'b1;
        cmd_channel       = w_exp_ch;
        cmd_startofpacket = 1'b1;
        cmd_endofpacket   = 1'b1;
        if (cmd_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        w_match    = rsp_valid && (rsp_channel == w_exp_ch);
        w_mismatch = rsp_valid && !w_match;
        // A matching response in the limit cycle takes priority over timeout.
        w_timeout  = !w_match && (r_cnt == CW'(TIMEOUT - 1));
        if (w_match || w_timeout) begin
          w_next_state = enable ? S_ISSUE : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

`ifdef ADC_SEQ_AVG_EN
  logic [13:0] r_acc;
  logic [1:0]  r_avg_cnt;
  logic [13:0] w_acc_sum;

  assign w_acc_sum  = r_acc + {2'b00, rsp_data};
  assign w_publish  = w_match && (r_avg_cnt == 2'd3);
  assign w_pub_data = w_acc_sum[13:2];
  // A timeout abandons the slot: partial sum dropped, pointer moves on.
  assign w_advance  = w_publish || w_timeout;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if (w_publish || w_timeout) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if (w_match) begin
      r_acc     <= w_acc_sum;
      r_avg_cnt <= r_avg_cnt + 2'd1;
    end
  end
`else
  assign w_publish  = w_match;
  assign w_pub_data = rsp_data;
  assign w_advance  = w_match || w_timeout;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_slot        <= '0;
      r_cnt         <= '0;
      r_sample_data <= '0;
      r_strobe      <= 1'b0;
      r_sample_slot <= '0;
      r_done        <= 1'b0;
      r_err_to      <= 1'b0;
      r_err_mm      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;

      // Counter only runs while waiting; it never exceeds TIMEOUT because
      // the state leaves WAIT_RSP at the limit.
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_RSP) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_mismatch) begin
        r_err_mm <= 1'b1;
      end
      if (w_timeout) begin
        r_err_to <= 1'b1;
      end

      if (w_publish) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_slot == 3'(i)) begin
            r_sample_data[12*i +: 12] <= w_pub_data;
          end
        end
        r_strobe      <= 1'b1;
        r_sample_slot <= r_slot;
      end

      if (w_advance) begin
        r_slot <= w_slot_next;
        r_done <= (r_slot == 3'(NUM_CH - 1));
      end
    end
  end

  assign sample_data   = r_sample_data;
  assign sample_strobe = r_strobe;
  assign sample_slot   = r_sample_slot;
  assign scan_done     = r_done;
  assign err_timeout   = r_err_to;
  assign err_mismatch  = r_err_mm;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// tb/tb_adc_cmd_sequencer.sv - self-checking bench for adc_cmd_sequencer
module tb_adc_cmd_sequencer;

  localparam int FIRST_CH = 1;
  localparam int NUM_CH   = 2;
  localparam int TIMEOUT  = 15;

  logic                 clk_clk = 1'b0;
  logic                 reset_reset;
  logic                 enable;
  logic                 cmd_valid;
  logic [4:0]           cmd_channel;
  logic                 cmd_startofpacket;
  logic                 cmd_endofpacket;
  logic                 cmd_ready;
  logic                 rsp_valid;
  logic [4:0]           rsp_channel;
  logic [11:0]          rsp_data;
  logic                 rsp_startofpacket;
  logic                 rsp_endofpacket;
  logic [12*NUM_CH-1:0] sample_data;
  logic                 sample_strobe;
  logic [2:0]           sample_slot;
  logic                 scan_done;
  logic                 err_timeout;
  logic                 err_mismatch;

  always #5 clk_clk = ~clk_clk;

  adc_cmd_sequencer #(
    .FIRST_CH(FIRST_CH),
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .enable           (enable),
    .cmd_valid        (cmd_valid),
    .cmd_channel      (cmd_channel),
    .cmd_startofpacket(cmd_startofpacket),
    .cmd_endofpacket  (cmd_endofpacket),
    .cmd_ready        (cmd_ready),
    .rsp_valid        (rsp_valid),
    .rsp_channel      (rsp_channel),
    .rsp_data         (rsp_data),
    .rsp_startofpacket(rsp_startofpacket),
    .rsp_endofpacket  (rsp_endofpacket),
    .sample_data      (sample_data),
    .sample_strobe    (sample_strobe),
    .sample_slot      (sample_slot),
    .scan_done        (scan_done),
    .err_timeout      (err_timeout),
    .err_mismatch     (err_mismatch)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transaction-level reference: an "outstanding" flag, a slot pointer,
  // elapsed cycles since accept, and the published results.
  bit          m_valid, m_out, m_strobe, m_done, m_err_to, m_err_mm;
  int          m_ptr, m_slot, m_elapsed;
  logic [11:0] m_smp [NUM_CH];

  int n_edge   = 0;
  int acc_edge = 0;
  int to_edge  = -1;
  int n_done   = 0;
  int n_strobe = 0;
  int acc_ch[$];

  task automatic m_reset();
    m_valid = 0; m_out = 0; m_strobe = 0; m_done = 0;
    m_err_to = 0; m_err_mm = 0;
    m_ptr = 0; m_slot = 0; m_elapsed = 0;
    for (int i = 0; i < NUM_CH; i++) m_smp[i] = 12'h000;
  endtask

  function automatic logic [12*NUM_CH-1:0] m_pack();
    logic [12*NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[12*i +: 12] = m_smp[i];
    return v;
  endfunction

  // One clock: compare outputs with the model, drive inputs, advance the
  // model across the coming edge, then wait for the next falling edge.
  task automatic step(input bit en, input bit rdy, input bit rv,
                      input logic [4:0] rch, input logic [11:0] rd, input bit rst);
    bit fin;
    check("cmd_valid", cmd_valid, m_valid);
    check("cmd_channel", cmd_channel, m_valid ? FIRST_CH + m_ptr : 0);
    check("cmd_sop", cmd_startofpacket, m_valid);
    check("cmd_eop", cmd_endofpacket, m_valid);
    check("sample_strobe", sample_strobe, m_strobe);
    check("sample_slot", sample_slot, m_slot);
    check("scan_done", scan_done, m_done);
    check("sample_data", sample_data, m_pack());
    check("err_timeout", err_timeout, m_err_to);
    check("err_mismatch", err_mismatch, m_err_mm);

    if (scan_done) n_done++;
    if (sample_strobe) n_strobe++;
    if (err_timeout && to_edge < 0) to_edge = n_edge;
    if (cmd_valid && rdy && !rst) acc_ch.push_back(int'(cmd_channel));

    reset_reset       = rst;
    enable            = en;
    cmd_ready         = rdy;
    rsp_valid         = rv;
    rsp_channel       = rch;
    rsp_data          = rd;
    rsp_startofpacket = $urandom_range(0, 1);
    rsp_endofpacket   = $urandom_range(0, 1);

    fin = 0;
    if (rst) begin
      m_reset();
    end else begin
      m_strobe = 0;
      m_done   = 0;
      if (m_out) begin
        m_elapsed++;
        if (rv && int'(rch) == FIRST_CH + m_ptr) begin
          m_smp[m_ptr] = rd;
          m_strobe     = 1;
          m_slot       = m_ptr;
          fin          = 1;
        end else begin
          if (rv) m_err_mm = 1;
          if (m_elapsed == TIMEOUT) begin
            m_err_to = 1;
            fin      = 1;
          end
        end
        if (fin) begin
          m_done  = (m_ptr == NUM_CH - 1);
          m_ptr   = (m_ptr + 1) % NUM_CH;
          m_out   = 0;
          m_valid = en;
        end
      end else if (m_valid && rdy) begin
        m_out     = 1;
        m_elapsed = 0;
        m_valid   = 0;
        acc_edge  = n_edge + 1;
      end else begin
        m_valid = m_valid || en;
      end
    end

    @(negedge clk_clk);
    n_edge++;
  endtask

  task automatic until_accept(input bit en);
    for (int k = 0; k < 8 && !m_out; k++) step(en, 1, 0, 5'd0, 12'h000, 0);
    check("accept_bound", m_out, 1);
  endtask

  task automatic run_slot(input bit en, input logic [4:0] ch, input logic [11:0] d);
    until_accept(en);
    step(en, 1, 1, ch, d, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    bit silent;
    reset_reset = 1; enable = 0; cmd_ready = 0; rsp_valid = 0;
    rsp_channel = 0; rsp_data = 0; rsp_startofpacket = 0; rsp_endofpacket = 0;
    m_reset();
    repeat (3) @(negedge clk_clk);

    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_cmd_channel", cmd_channel, 0);
    check("reset_sample_data", sample_data, 0);
    check("reset_errs", {err_timeout, err_mismatch}, 0);

    // Two-slot scan with prompt responses.
    run_slot(1, 5'd1, 12'h123);
    run_slot(1, 5'd2, 12'hABC);
    check("req022_data", sample_data, 24'hABC123);
    for (int k = 0; k < 8 && acc_ch.size() < 3; k++) step(1, 1, 0, 5'd0, 12'h000, 0);
    check("req022_ncmd", acc_ch.size(), 3);
    check("req022_cmd0", acc_ch[0], 1);
    check("req022_cmd1", acc_ch[1], 2);
    check("req022_cmd2", acc_ch[2], 1);
    check("req022_done", n_done, 1);

    // Backpressure: command held while cmd_ready is low.
    step(0, 0, 0, 5'd0, 12'h000, 1);
    n_strobe = 0;
    to_edge  = -1;
    step(1, 0, 0, 5'd0, 12'h000, 0);
    for (int k = 0; k < 5; k++) begin
      check("req023_hold_valid", cmd_valid, 1);
      check("req023_hold_ch", cmd_channel, 1);
      step(1, 0, 0, 5'd0, 12'h000, 0);
    end
    n0 = acc_ch.size();
    step(1, 1, 0, 5'd0, 12'h000, 0);
    t0 = acc_edge;
    repeat (3) step(1, 1, 0, 5'd0, 12'h000, 0);
    check("req023_transfers", acc_ch.size() - n0, 1);

    // Silent ADC: the slot times out and the scan moves on.
    for (int k = 0; k < 40 && to_edge < 0; k++) step(1, 1, 0, 5'd0, 12'h000, 0);
    check("req024_latency", to_edge - t0, TIMEOUT);
    check("req024_no_strobe", n_strobe, 0);
    check("req024_next_ch", acc_ch[$], 2);

    // Wrong channel first, then the right one.
    step(1, 0, 0, 5'd0, 12'h000, 1);
    until_accept(1);
    step(1, 1, 1, 5'd5, 12'h7FF, 0);
    step(1, 1, 1, 5'd1, 12'h040, 0);
    check("req025_mismatch", err_mismatch, 1);
    check("req025_slot0", sample_data[11:0], 12'h040);

    // Responses while idle or issuing are ignored; enable drop keeps the command.
    step(0, 0, 0, 5'd0, 12'h000, 1);
    n_strobe = 0;
    repeat (3) step(0, 0, 1, 5'd1, 12'h3C3, 0);
    step(1, 0, 1, 5'd1, 12'h3C3, 0);
    repeat (3) step(0, 0, 1, 5'd1, 12'h3C3, 0);
    check("req014_held", cmd_valid, 1);
    step(0, 1, 0, 5'd0, 12'h000, 0);
    step(0, 0, 1, 5'd1, 12'h0AA, 0);
    step(0, 0, 0, 5'd0, 12'h000, 0);
    check("req013_idle", cmd_valid, 0);
    check("req015_errs", {err_timeout, err_mismatch}, 0);
    check("req015_strobes", n_strobe, 1);

    // Reset while waiting; the late response must not land.
    run_slot(1, 5'd2, 12'h111);
    until_accept(1);
    step(1, 1, 1, 5'd1, 12'h222, 1);
    step(0, 0, 1, 5'd1, 12'h222, 0);
    check("req027_data", sample_data, 0);
    check("req027_errs", {err_timeout, err_mismatch}, 0);
    check("req027_valid", cmd_valid, 0);
    until_accept(1);
    check("req027_restart_ch", acc_ch[$], 1);

    // Randomized traffic against the model.
    silent = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          en, rdy, rv, rst;
      logic [4:0]  rch;
      logic [11:0] rd;
      int          sel;
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 7) != 0);
      rdy = $urandom_range(0, 1);
      rd  = 12'($urandom);
      rv  = 0;
      rch = 5'($urandom);
      if (!m_out) silent = ($urandom_range(0, 3) == 0);
      if (m_out) begin
        sel = $urandom_range(0, 7);
        if (sel <= 2 && !silent) begin
          rv  = 1;
          rch = 5'(FIRST_CH + m_ptr);
        end else if (sel == 3) begin
          rv = 1;
          if (int'(rch) == FIRST_CH + m_ptr) rch = rch ^ 5'd1;
        end
      end else begin
        rv = ($urandom_range(0, 3) == 0);
      end
      step(en, rdy, rv, rch, rd, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
